slam_sequencer: RTL and testbench
=================================

Name: slam_sequencer

Overview:
Parametrised top-level controller for the Hector SLAM FPGA pipeline. It sequences pose reads, beam fetches, ray tracing and VGA drawing across NUM_SCANS scans of BEAMS_PER_SCAN beams each. Beams are dispatched to NUM_CHANNELS parallel Bresenham engines, and the scan and beam counters are kept internally. It adds configurable memory latency, a continuous-run mode, and a watchdog with a sticky fault.

Parameters:
NUM_CHANNELS, 2, number of Bresenham engines (1..8)
BEAMS_PER_SCAN, 360, beams per scan (>=1)
NUM_SCANS, 16, scans per run (>=1)
MEM_LATENCY, 1, scan-memory read latency in cycles (>=1)
TIMEOUT_CYCLES, 65535, watchdog limit; 0 disables the watchdog

Ports:
clock  in  1  system clock
reset  in  1  reset
start  in  1  begin a run when idle
continuous  in  1  restart automatically after draw; sampled when DRAW exits
address_enable  out  1  advance scan-memory read address
address_reset  out  1  reset scan-memory address to 0
position_enable  out  1  latch pose word from memory
scan_index  out  $clog2(NUM_SCANS)  current scan
beam_index  out  $clog2(BEAMS_PER_SCAN)  next beam to dispatch
bresenham_start  out  NUM_CHANNELS  one-hot start pulse
bresenham_busy  in  NUM_CHANNELS  per-engine busy
use_bresenham_indices  out  1  occupancy grid addressed by engines
zero_occupancy_grid  out  1  clear grid request
occupancy_busy  in  1  grid clear/write in progress
draw_start  out  1  one-cycle VGA draw request
vga_busy  in  1  VGA draw in progress
done  out  1  one-cycle pulse at run completion
error  out  1  sticky watchdog fault

Behaviour:
- Reset: reset, synchronous, active-high.
  - State goes to CLEAR; scan_index, beam_index, reserved mask, wait and watchdog counters go to 0; error clears.
  - All outputs are 0 except those CLEAR drives.
  - Reset mid-run aborts immediately; no draw or done is issued.
- Outputs are Moore-decoded from state and counters; all defaults are 0.
- Channel availability: reserved[i] is set for exactly the one cycle after bresenham_start[i]. Engines raise busy within one cycle of start. Channel i is free iff !bresenham_busy[i] && !reserved[i].
- States:
  - CLEAR: zero_occupancy_grid=1, address_reset=1. Minimum 1 cycle; go to IDLE on the first cycle with !occupancy_busy.
  - IDLE: go to POS_WAIT when start && !occupancy_busy.
  - POS_WAIT: stay MEM_LATENCY cycles, then go to READ_POS.
  - READ_POS: position_enable=1 and address_enable=1 (one cycle). Go to BEAM_WAIT.
  - BEAM_WAIT: stay MEM_LATENCY cycles, then go to DISPATCH.
  - DISPATCH: wait for any free channel while !occupancy_busy. In the issuing cycle:
    - pulse bresenham_start for the lowest-index free channel;
    - pulse address_enable;
    - increment beam_index.
    - If the issued beam was BEAMS_PER_SCAN-1, go to DRAIN; else go to BEAM_WAIT.
  - DRAIN: wait until all channels are free and !occupancy_busy.
    - Last scan (NUM_SCANS-1): go to DRAW.
    - Otherwise: increment scan_index, clear beam_index, go to POS_WAIT.
  - DRAW: draw_start=1 on the entry cycle only. vga_busy is ignored on the entry cycle. On the first later cycle with !vga_busy:
    - pulse done and address_reset;
    - clear scan_index and beam_index;
    - go to POS_WAIT if continuous=1, else IDLE.
  - FAULT: all control outputs 0, error=1. Exit only by reset.
- use_bresenham_indices = 1 whenever any bit of (bresenham_busy|reserved) is set, outside CLEAR and IDLE.
- Watchdog: counts consecutive cycles spent in DISPATCH without issuing, in DRAIN, or in DRAW. It clears on any issue or state change. When it reaches TIMEOUT_CYCLES (nonzero), go to FAULT.
- start is ignored outside IDLE.
- A single-beam, single-scan run is legal: DISPATCH goes directly to DRAIN, then to DRAW.

Test Plan:
1. Reset release with occupancy_busy held high 5 cycles -> zero_occupancy_grid and address_reset high 6 cycles, then IDLE.
2. NUM_CHANNELS=2, BEAMS_PER_SCAN=4, NUM_SCANS=2, engines busy 3 cycles -> 8 start pulses alternating ch0/ch1. Each scan has 1 position_enable and 5 address_enable; exactly one draw_start and one done.
3. Channel 0 stuck busy, channel 1 idle-fast -> all beams issued to channel 1; no start while reserved[1] is set.
4. continuous=1 across two runs -> after done, scan_index=0 and POS_WAIT entered next cycle; a start pulse mid-run changes nothing.
5. TIMEOUT_CYCLES=20, all channels stuck busy -> FAULT entered 20 cycles into DISPATCH; error stays 1 until reset, then clears.
6. MEM_LATENCY=3 -> exactly 3 cycles between address_enable and the next start or position_enable.

Source files
------------

// File: rtl/slam_sequencer.sv
// Top-level sequencer for the Hector SLAM pipeline: pose read, per-beam dispatch to
// parallel Bresenham engines, drain, VGA draw, with a watchdog that latches a fault.
module slam_sequencer #(
    parameter int NUM_CHANNELS   = 2,
    parameter int BEAMS_PER_SCAN = 360,
    parameter int NUM_SCANS      = 16,
    parameter int MEM_LATENCY    = 1,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int SCAN_W = (NUM_SCANS > 1) ? $clog2(NUM_SCANS) : 1,
    localparam int BEAM_W = (BEAMS_PER_SCAN > 1) ? $clog2(BEAMS_PER_SCAN) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    continuous,
    output logic                    address_enable,
    output logic                    address_reset,
    output logic                    position_enable,
    output logic [SCAN_W-1:0]       scan_index,
    output logic [BEAM_W-1:0]       beam_index,
    output logic [NUM_CHANNELS-1:0] bresenham_start,
    input  logic [NUM_CHANNELS-1:0] bresenham_busy,
    output logic                    use_bresenham_indices,
    output logic                    zero_occupancy_grid,
    input  logic                    occupancy_busy,
    output logic                    draw_start,
    input  logic                    vga_busy,
    output logic                    done,
    output logic                    error
);

    localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NUM_SCANS - 1);
    localparam logic [BEAM_W-1:0] BEAM_LAST = BEAM_W'(BEAMS_PER_SCAN - 1);

    typedef enum logic [3:0] {
        S_CLEAR, S_IDLE, S_POS_WAIT, S_READ_POS, S_BEAM_WAIT,
        S_DISPATCH, S_DRAIN, S_DRAW, S_FAULT
    } state_t;

    state_t                  state_reg, state_next;
    logic [SCAN_W-1:0]       scan_reg, scan_next;
    logic [BEAM_W-1:0]       beam_reg, beam_next;
    logic [WAIT_W-1:0]       wait_reg, wait_next;
    logic [WD_W-1:0]         wd_reg, wd_next;
    logic [NUM_CHANNELS-1:0] reserved_reg;
    logic                    entry_reg;

    logic [NUM_CHANNELS-1:0] free, grant;
    logic [NUM_CHANNELS:0]   taken;
    logic                    issue, watched, state_change;

    // An engine is unusable the cycle after its start, before its busy is visible.
    assign free     = ~bresenham_busy & ~reserved_reg;
    assign taken[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_pick
            assign grant[gi]    = free[gi] & ~taken[gi];
            assign taken[gi+1]  = taken[gi] | free[gi];
        end
    endgenerate

    assign scan_index = scan_reg;
    assign beam_index = beam_reg;

    always_comb begin
        state_next            = state_reg;
        scan_next             = scan_reg;
        beam_next             = beam_reg;
        address_enable        = 1'b0;
        address_reset         = 1'b0;
        position_enable       = 1'b0;
        bresenham_start       = '0;
        zero_occupancy_grid   = 1'b0;
        draw_start            = 1'b0;
        done                  = 1'b0;
        error                 = 1'b0;
        issue                 = 1'b0;
        use_bresenham_indices = 1'b0;

        unique case (state_reg)
            S_CLEAR: begin
                zero_occupancy_grid = 1'b1;
                address_reset       = 1'b1;
                if (!occupancy_busy)
                    state_next = S_IDLE;
            end
            S_IDLE: begin
                if (start && !occupancy_busy)
                    state_next = S_POS_WAIT;
            end
            S_POS_WAIT: begin
                if (wait_reg == WAIT_LAST)
                    state_next = S_READ_POS;
            end
            S_READ_POS: begin
                position_enable = 1'b1;
                address_enable  = 1'b1;
                state_next      = S_BEAM_WAIT;
            end
            S_BEAM_WAIT: begin
                if (wait_reg == WAIT_LAST)
                    state_next = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (!occupancy_busy && taken[NUM_CHANNELS]) begin
                    issue           = 1'b1;
                    bresenham_start = grant;
                    address_enable  = 1'b1;
                    beam_next       = beam_reg + BEAM_W'(1);
                    state_next      = (beam_reg == BEAM_LAST) ? S_DRAIN : S_BEAM_WAIT;
                end
            end
            S_DRAIN: begin
                if ((&free) && !occupancy_busy) begin
                    if (scan_reg == SCAN_LAST) begin
                        state_next = S_DRAW;
                    end else begin
                        scan_next  = scan_reg + SCAN_W'(1);
                        beam_next  = '0;
                        state_next = S_POS_WAIT;
                    end
                end
            end
            S_DRAW: begin
                // The VGA block may not have raised busy yet on the request cycle.
                draw_start = entry_reg;
                if (!entry_reg && !vga_busy) begin
                    done          = 1'b1;
                    address_reset = 1'b1;
                    scan_next     = '0;
                    beam_next     = '0;
                    state_next    = continuous ? S_POS_WAIT : S_IDLE;
                end
            end
            S_FAULT: begin
                error = 1'b1;
            end
            default: begin
                state_next = S_FAULT;
            end
        endcase

        watched = (state_reg == S_DISPATCH) || (state_reg == S_DRAIN) || (state_reg == S_DRAW);
        if ((TIMEOUT_CYCLES != 0) && watched && !issue &&
            (state_next == state_reg) && (wd_reg == WD_LAST))
            state_next = S_FAULT;

        state_change = (state_next != state_reg);
        wait_next    = state_change ? '0 : wait_reg + WAIT_W'(1);
        wd_next      = (watched && !issue && !state_change) ? wd_reg + WD_W'(1) : '0;

        if ((state_reg != S_CLEAR) && (state_reg != S_IDLE) && (state_reg != S_FAULT))
            use_bresenham_indices = |(bresenham_busy | reserved_reg);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= S_CLEAR;
            scan_reg     <= '0;
            beam_reg     <= '0;
            wait_reg     <= '0;
            wd_reg       <= '0;
            reserved_reg <= '0;
            entry_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            scan_reg     <= scan_next;
            beam_reg     <= beam_next;
            wait_reg     <= wait_next;
            wd_reg       <= wd_next;
            reserved_reg <= bresenham_start;
            entry_reg    <= state_change;
        end
    end

endmodule

// File: tb/tb_slam_sequencer.sv
// Randomized bench for slam_sequencer: behavioural engines/VGA/grid environment and a
// phase-level reference model predicting every output each cycle.
module tb_slam_sequencer;

    localparam int NC  = 2;
    localparam int BPS = 4;
    localparam int NS  = 2;
    localparam int ML  = 3;
    localparam int TO  = 20;
    localparam int SW  = (NS > 1) ? $clog2(NS) : 1;
    localparam int BW  = (BPS > 1) ? $clog2(BPS) : 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          address_enable, address_reset, position_enable;
    logic [SW-1:0] scan_index;
    logic [BW-1:0] beam_index;
    logic [NC-1:0] bresenham_start;
    logic [NC-1:0] bresenham_busy = '0;
    logic          use_bresenham_indices, zero_occupancy_grid;
    logic          occupancy_busy = 1'b0;
    logic          draw_start;
    logic          vga_busy = 1'b0;
    logic          done, error;

    slam_sequencer #(
        .NUM_CHANNELS(NC), .BEAMS_PER_SCAN(BPS), .NUM_SCANS(NS),
        .MEM_LATENCY(ML), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .continuous(continuous),
        .address_enable(address_enable), .address_reset(address_reset),
        .position_enable(position_enable), .scan_index(scan_index),
        .beam_index(beam_index), .bresenham_start(bresenham_start),
        .bresenham_busy(bresenham_busy), .use_bresenham_indices(use_bresenham_indices),
        .zero_occupancy_grid(zero_occupancy_grid), .occupancy_busy(occupancy_busy),
        .draw_start(draw_start), .vga_busy(vga_busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    // Environment knobs
    logic          rst_req    = 1'b1;
    int            occ_mode   = 0;      // 0 random, 1 high, 2 low
    int            start_mode = 2;      // 0 random, 1 high, 2 low
    logic [NC-1:0] stuck      = '0;
    logic          cont       = 1'b0;
    int            bcnt [NC];
    int            vcnt       = 0;
    logic [NC-1:0] prev_start = '0;
    logic          prev_draw  = 1'b0;

    // Reference model: phase plus remaining-delay countdown and plain integer tallies
    typedef enum int {M_CLEAR, M_IDLE, M_POSW, M_RDPOS, M_BEAMW, M_DISP, M_DRAIN, M_DRAW, M_FAULT} mph_t;
    mph_t          m_ph = M_CLEAR;
    int            m_delay = 0, m_scan = 0, m_beam = 0, m_stall = 0;
    logic          m_entry = 1'b0;
    logic [NC-1:0] m_resv = '0;
    logic          model_valid = 1'b0;

    int run_starts = 0, run_pos = 0, run_addr = 0, run_draw = 0, runs = 0;

    task automatic model_reset();
        m_ph = M_CLEAR; m_delay = 0; m_scan = 0; m_beam = 0; m_stall = 0;
        m_entry = 1'b0; m_resv = '0;
    endtask

    task automatic model_eval();
        logic [NC-1:0] fr, e_start;
        logic [7:0]    e_ctrl;
        logic [BW-1:0] e_beam;
        logic [SW-1:0] e_scan;
        logic          ae, ar, pe, zg, ub, ds, dn, er, iss;
        int            ch;
        mph_t          nxt;
        fr = ~bresenham_busy & ~m_resv;
        e_start = '0; ae = 0; ar = 0; pe = 0; zg = 0; ds = 0; dn = 0; er = 0; iss = 0;
        e_beam = BW'(m_beam);
        e_scan = SW'(m_scan);
        nxt = m_ph;
        case (m_ph)
            M_CLEAR: begin zg = 1; ar = 1; if (!occupancy_busy) nxt = M_IDLE; end
            M_IDLE:  if (start && !occupancy_busy) nxt = M_POSW;
            M_POSW:  if (m_delay <= 1) nxt = M_RDPOS; else m_delay--;
            M_RDPOS: begin pe = 1; ae = 1; nxt = M_BEAMW; end
            M_BEAMW: if (m_delay <= 1) nxt = M_DISP; else m_delay--;
            M_DISP: begin
                if (!occupancy_busy && fr != 0) begin
                    ch = 0;
                    for (int i = NC - 1; i >= 0; i--) if (fr[i]) ch = i;
                    e_start[ch] = 1'b1; ae = 1; iss = 1;
                    m_beam++;
                    nxt = (m_beam == BPS) ? M_DRAIN : M_BEAMW;
                end
            end
            M_DRAIN: begin
                if (fr == '1 && !occupancy_busy) begin
                    if (m_scan == NS - 1) nxt = M_DRAW;
                    else begin m_scan++; m_beam = 0; nxt = M_POSW; end
                end
            end
            M_DRAW: begin
                ds = m_entry;
                if (!m_entry && !vga_busy) begin
                    dn = 1; ar = 1; m_scan = 0; m_beam = 0;
                    nxt = continuous ? M_POSW : M_IDLE;
                end
            end
            default: er = 1;
        endcase
        ub = (m_ph != M_CLEAR && m_ph != M_IDLE && m_ph != M_FAULT) &&
             ((bresenham_busy | m_resv) != 0);
        if ((m_ph == M_DISP || m_ph == M_DRAIN || m_ph == M_DRAW) && nxt == m_ph && !iss) begin
            m_stall++;
            if (m_stall == TO) nxt = M_FAULT;
        end else begin
            m_stall = 0;
        end
        e_ctrl = {er, dn, ds, ub, zg, pe, ar, ae};
        check("ctrl{err,done,draw,usebi,zgrid,pos,arst,aen}",
              {error, done, draw_start, use_bresenham_indices, zero_occupancy_grid,
               position_enable, address_reset, address_enable}, e_ctrl);
        check("bresenham_start", bresenham_start, e_start);
        check("scan_index", scan_index, e_scan);
        check("beam_index", beam_index, e_beam);
        m_entry = (nxt == M_DRAW) && (m_ph != M_DRAW);
        if (nxt != m_ph && (nxt == M_POSW || nxt == M_BEAMW)) m_delay = ML;
        if (nxt != m_ph) m_stall = 0;
        m_resv = e_start;
        m_ph = nxt;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < NC; i++) begin
            if (prev_start[i]) bcnt[i] = $urandom_range(1, 4);
            else if (bcnt[i] > 0) bcnt[i]--;
            bresenham_busy[i] = stuck[i] || (bcnt[i] > 0);
        end
        if (prev_draw) vcnt = $urandom_range(0, 5);
        else if (vcnt > 0) vcnt--;
        vga_busy = (vcnt > 0) || ($urandom_range(0, 3) == 0);
        occupancy_busy = (occ_mode == 1) ? 1'b1 : (occ_mode == 2) ? 1'b0 : ($urandom_range(0, 9) == 0);
        start = (start_mode == 1) ? 1'b1 : (start_mode == 2) ? 1'b0 : ($urandom_range(0, 7) == 0);
        continuous = cont;
        reset = rst_req;
        #1;
        if (rst_req) begin
            model_reset();
            model_valid = 1'b1;
            run_starts = 0; run_pos = 0; run_addr = 0; run_draw = 0;
        end else if (model_valid) begin
            model_eval();
            run_starts += $countones(bresenham_start);
            run_pos    += int'(position_enable);
            run_addr   += int'(address_enable);
            run_draw   += int'(draw_start);
            if (done) begin
                runs++;
                $display("run %0d done at cycle %0d: starts=%0d pos=%0d addr=%0d draw=%0d cont=%0b",
                         runs, cyc, run_starts, run_pos, run_addr, run_draw, continuous);
                check("run_starts", run_starts, NS * BPS);
                check("run_pos_enable", run_pos, NS);
                check("run_addr_enable", run_addr, NS * (BPS + 1));
                check("run_draw_start", run_draw, 1);
                run_starts = 0; run_pos = 0; run_addr = 0; run_draw = 0;
            end
        end
        prev_start = bresenham_start;
        prev_draw  = draw_start;
    endtask

    int fault_hold = 0;
    task automatic random_cycle();
        rst_req = ($urandom_range(0, 499) == 0) || (fault_hold > 3);
        if ((cyc % 40) == 0) cont = 1'($urandom_range(0, 1));
        step();
        if (m_ph == M_FAULT) fault_hold++; else fault_hold = 0;
    endtask

    initial begin
        int n, c0, c1, pe_cyc, err_cyc;
        for (int i = 0; i < NC; i++) bcnt[i] = 0;

        // Reset release while the grid clear is still running
        rst_req = 1'b1; occ_mode = 1; start_mode = 2;
        repeat (2) step();
        rst_req = 1'b0; n = 0;
        for (int k = 0; k < 5; k++) begin step(); if (zero_occupancy_grid) n++; end
        occ_mode = 2;
        for (int k = 0; k < 4; k++) begin step(); if (zero_occupancy_grid) n++; end
        check("clear_len", n, 6);

        // Free-running random traffic, all engines healthy
        occ_mode = 0; start_mode = 0;
        for (int k = 0; k < 3000; k++) random_cycle();

        // Channel 0 stuck busy: everything must go to channel 1
        stuck = 2'b01; c0 = 0; c1 = 0;
        for (int k = 0; k < 1500; k++) begin
            random_cycle();
            if (bresenham_start[0]) c0++;
            if (bresenham_start[1]) c1++;
        end
        check("ch0_starts_while_stuck", c0, 0);
        check("ch1_used_while_ch0_stuck", c1 > 0, 1);

        // All engines stuck: watchdog must trip 20 cycles into DISPATCH
        stuck = '1; occ_mode = 2; start_mode = 1; cont = 1'b0;
        rst_req = 1'b1; step(); rst_req = 1'b0;
        pe_cyc = -1; err_cyc = -1;
        for (int k = 0; k < 80 && err_cyc < 0; k++) begin
            step();
            if (position_enable && pe_cyc < 0) pe_cyc = cyc;
            if (error === 1'b1) err_cyc = cyc;
        end
        check("fault_delay_from_pos_read", err_cyc - pe_cyc, 4 + TO);
        repeat (10) step();
        check("error_sticky", error, 1);
        stuck = '0; start_mode = 2;
        rst_req = 1'b1; step(); rst_req = 1'b0;
        step();
        check("error_cleared_by_reset", error, 0);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
